if_fetch: RTL and testbench
===========================

# if_fetch

Instruction fetch stage for the 5-stage RV32I pipeline: the producer side of the `pc`/`inst` interface consumed by the decode stage through `if_id`. It reads instructions one byte at a time from a byte-wide RAM port and assembles them little-endian into 32-bit words. Each assembled word is presented with its PC and held until the pipeline accepts it. Redirects from decode (`jump_flag`/`jump_addr`) and stalls from `ctrl` are applied here.

## Interface
- `AddrLen`, 32: address and PC width.
- `InstLen`, 32: instruction width.
- `RESET_PC`, 32'h0: PC fetched after reset.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high (`ResetEnable` = 1).
- `stall`  in  1  from `ctrl`; 1 = downstream does not accept the held instruction this cycle.
- `jump_flag`  in  1  from decode; redirect request.
- `jump_addr`  in  AddrLen  redirect target. Bits [1:0] are ignored and treated as 0.
- `mem_busy`  in  1  RAM port is taken by the data side this cycle; fetch must not issue.
- `mem_din`  in  8  read byte, valid the cycle after its `mem_rd_en`.
- `mem_a`  out  AddrLen  byte address, combinational.
- `mem_rd_en`  out  1  byte read request, combinational.
- `pc_o`  out  AddrLen  PC of the presented instruction, registered.
- `inst_o`  out  InstLen  presented instruction, registered.
- `inst_valid`  out  1  `pc_o`/`inst_o` hold a complete instruction, registered.

## Operation
- State: `FETCH` or `VALID`.
  - `fetch_pc` (word aligned).
  - `icnt` (bytes issued, 0..4) and `rcnt` (bytes received, 0..4).
  - `pend` (a byte was issued last cycle).
  - `buf[3:0]` (bytes).
- Reset values:
  - state = FETCH, `fetch_pc` = RESET_PC, `icnt` = `rcnt` = 0, `pend` = 0.
  - `pc_o` = 0, `inst_o` = 0, `inst_valid` = 0.
  - `rst` has priority over every other input.
- Priority each edge: `rst` > `jump_flag` > normal operation.
- Jump, in any state and regardless of `stall`:
  - `fetch_pc` ← {`jump_addr`[31:2], 2'b00}; `icnt`, `rcnt`, `pend` ← 0.
  - `inst_valid` ← 0; state ← FETCH.
  - Any byte in flight is discarded; its return next cycle is ignored because `pend` = 0.
  - `mem_rd_en` = 0 in any cycle with `jump_flag` = 1.
- FETCH, each cycle:
  - Receive: if `pend`, `buf[rcnt]` ← `mem_din` and `rcnt`++.
  - Issue: if `icnt` < 4 and !`mem_busy` and !`jump_flag`, then `mem_a` = `fetch_pc` + `icnt`, `mem_rd_en` = 1, `icnt`++ and `pend` ← 1. Otherwise `mem_rd_en` = 0, `mem_a` = `fetch_pc`, `pend` ← 0.
  - When the byte that makes `rcnt` = 4 is stored:
    - `inst_o` ← {`mem_din`, `buf[2]`, `buf[1]`, `buf[0]`}.
    - `pc_o` ← `fetch_pc`, `inst_valid` ← 1, state ← VALID.
  - `stall` has no effect in FETCH.
- VALID:
  - No memory requests.
  - If `stall`, hold all outputs.
  - If !`stall` (handoff), `fetch_pc` ← `fetch_pc` + 4 (wraps modulo 2^32), counters ← 0, `inst_valid` ← 0, state ← FETCH.
- `pc_o`/`inst_o` keep their last value while `inst_valid` = 0.

## Timing
- Unobstructed fetch, cycles c0..c5 after entering FETCH:
  - c0: issue addr+0.
  - c1: capture b0, issue +1.
  - c2: capture b1, issue +2.
  - c3: capture b2, issue +3.
  - c4: capture b3.
  - c5: `inst_valid` = 1.
- Throughput: 6 cycles per instruction with no stall or busy. The next issue is in c6.
- Each `mem_busy` cycle during an issue slot delays completion by 1 cycle. Bytes already issued are still captured.
- After reset deasserts, the first `mem_rd_en` is in the first cycle, with `mem_a` = RESET_PC.
- A jump sampled at edge E produces `mem_a` = target with `mem_rd_en` = 1 in the cycle after E (if not busy). Its instruction is valid 5 cycles later.

## Test plan
- Reset, RAM[0..3] = 13 05 10 00 → `inst_valid` = 1 in c5 with `inst_o` = 32'h00100513 and `pc_o` = 0. In c6, `mem_a` = 4 with `mem_rd_en` = 1.
- `stall` = 1 for 3 cycles while VALID → `inst_o`/`pc_o`/`inst_valid` stable and `mem_rd_en` = 0. On release, the next cycle issues `mem_a` = 4 and `inst_valid` = 0.
- `mem_busy` = 1 in c1–c2 → no issue in those cycles, b0 still captured, `inst_valid` in c7, `inst_o` correct.
- `jump_flag` = 1 with `jump_addr` = 32'h102 in c2 → `mem_rd_en` = 0 in c2. In c3, `mem_a` = 32'h100. The in-flight byte is discarded. Result: `pc_o` = 32'h100 with the bytes from 0x100..0x103.
- `jump_flag` = 1 while VALID with `stall` = 1 → `inst_valid` = 0 the next cycle and fetch restarts at the target.
- `rst` = 1 in c3 mid-fetch (with `jump_flag` also 1) → next cycle all outputs are at reset values and refetch starts from RESET_PC.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction fetch stage: assembles 32-bit instructions from a byte-wide RAM
// port, presents them with their PC and holds them until decode accepts.
module if_fetch #(
    parameter int                 AddrLen  = 32,
    parameter int                 InstLen  = 32,
    parameter logic [AddrLen-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               jump_flag,
    input  logic [AddrLen-1:0] jump_addr,
    input  logic               mem_busy,
    input  logic [7:0]         mem_din,
    output logic [AddrLen-1:0] mem_a,
    output logic               mem_rd_en,
    output logic [AddrLen-1:0] pc_o,
    output logic [InstLen-1:0] inst_o,
    output logic               inst_valid
);

    localparam logic [0:0] S_FETCH = 1'b0;
    localparam logic [0:0] S_VALID = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [AddrLen-1:0] fetch_pc_q, fetch_pc_d;
    logic [2:0]         icnt_q, icnt_d;
    logic [2:0]         rcnt_q, rcnt_d;
    logic               pend_q, pend_d;
    logic [3:0][7:0]    byte_buf_q, byte_buf_d;
    logic [AddrLen-1:0] pc_o_q, pc_o_d;
    logic [InstLen-1:0] inst_o_q, inst_o_d;
    logic               inst_valid_q, inst_valid_d;
    logic               issue;

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        icnt_d       = icnt_q;
        rcnt_d       = rcnt_q;
        pend_d       = pend_q;
        byte_buf_d   = byte_buf_q;
        pc_o_d       = pc_o_q;
        inst_o_d     = inst_o_q;
        inst_valid_d = inst_valid_q;

        issue     = (state_q == S_FETCH) && (icnt_q < 3'd4) && !mem_busy && !jump_flag;
        mem_rd_en = issue;
        mem_a     = issue ? fetch_pc_q + AddrLen'(icnt_q) : fetch_pc_q;

        if (jump_flag) begin
            // An in-flight byte is dropped: clearing pend makes its return invisible.
            fetch_pc_d   = {jump_addr[AddrLen-1:2], 2'b00};
            icnt_d       = '0;
            rcnt_d       = '0;
            pend_d       = 1'b0;
            inst_valid_d = 1'b0;
            state_d      = S_FETCH;
        end else begin
            case (state_q)
                S_FETCH: begin
                    pend_d = issue;
                    if (issue) icnt_d = icnt_q + 3'd1;
                    if (pend_q) begin
                        byte_buf_d[rcnt_q[1:0]] = mem_din;
                        rcnt_d = rcnt_q + 3'd1;
                        if (rcnt_q == 3'd3) begin
                            inst_o_d     = InstLen'({mem_din, byte_buf_q[2], byte_buf_q[1], byte_buf_q[0]});
                            pc_o_d       = fetch_pc_q;
                            inst_valid_d = 1'b1;
                            state_d      = S_VALID;
                        end
                    end
                end
                default: begin
                    if (!stall) begin
                        fetch_pc_d   = fetch_pc_q + AddrLen'(4);
                        icnt_d       = '0;
                        rcnt_d       = '0;
                        pend_d       = 1'b0;
                        inst_valid_d = 1'b0;
                        state_d      = S_FETCH;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_FETCH;
            fetch_pc_q   <= RESET_PC;
            icnt_q       <= '0;
            rcnt_q       <= '0;
            pend_q       <= 1'b0;
            byte_buf_q   <= '0;
            pc_o_q       <= '0;
            inst_o_q     <= '0;
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            icnt_q       <= icnt_d;
            rcnt_q       <= rcnt_d;
            pend_q       <= pend_d;
            byte_buf_q   <= byte_buf_d;
            pc_o_q       <= pc_o_d;
            inst_o_q     <= inst_o_d;
            inst_valid_q <= inst_valid_d;
        end
    end

    assign pc_o       = pc_o_q;
    assign inst_o     = inst_o_q;
    assign inst_valid = inst_valid_q;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: byte RAM model with one-cycle read latency,
// inputs driven and outputs checked on the falling edge.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst, stall, jump_flag, mem_busy;
    logic [31:0] jump_addr;
    logic [7:0]  mem_din;
    logic [31:0] mem_a, pc_o, inst_o;
    logic        mem_rd_en, inst_valid;

    logic [7:0]  ram [0:511];
    int          n_chk = 0;
    int          n_pass = 0;

    if_fetch #(.AddrLen(32), .InstLen(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .stall(stall), .jump_flag(jump_flag),
        .jump_addr(jump_addr), .mem_busy(mem_busy), .mem_din(mem_din),
        .mem_a(mem_a), .mem_rd_en(mem_rd_en), .pc_o(pc_o), .inst_o(inst_o),
        .inst_valid(inst_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_rd_en) mem_din <= ram[mem_a[8:0]];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Drive one cycle's inputs just after the falling edge, let comb logic settle.
    task automatic cyc(input logic r, input logic st, input logic jf,
                       input logic [31:0] ja, input logic bz);
        @(negedge clk);
        rst = r; stall = st; jump_flag = jf; jump_addr = ja; mem_busy = bz;
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic chk_rd(input string tag, input logic en, input logic [31:0] a);
        chk({tag, "_rd_en"}, {31'b0, mem_rd_en}, {31'b0, en});
        if (en) chk({tag, "_a"}, mem_a, a);
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] ins);
        chk({tag, "_valid"}, {31'b0, inst_valid}, {31'b0, v});
        chk({tag, "_pc"}, pc_o, pc);
        chk({tag, "_inst"}, inst_o, ins);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) ram[i] = 8'h00;
        ram[0] = 8'h13; ram[1] = 8'h05; ram[2] = 8'h10; ram[3] = 8'h00;
        ram[4] = 8'h93; ram[5] = 8'h00; ram[6] = 8'h20; ram[7] = 8'h00;
        ram[9'h100] = 8'hef; ram[9'h101] = 8'hbe; ram[9'h102] = 8'had; ram[9'h103] = 8'hde;
        rst = 1'b1; stall = 1'b0; jump_flag = 1'b0; jump_addr = '0; mem_busy = 1'b0;

        // Basic fetch and stall hold
        do_reset(); do_reset();
        idle();                                   // c0
        chk_out("rst", 1'b0, 32'h0, 32'h0);
        chk_rd("c0", 1'b1, 32'h0);
        idle(); chk_rd("c1", 1'b1, 32'h1);
        idle(); chk_rd("c2", 1'b1, 32'h2);
        idle(); chk_rd("c3", 1'b1, 32'h3);
        idle(); chk_rd("c4", 1'b0, 32'h0);
        chk("c4_valid", {31'b0, inst_valid}, 32'h0);
        for (int i = 0; i < 3; i++) begin         // c5..c7 stalled
            cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
            chk_out("stall", 1'b1, 32'h0, 32'h00100513);
            chk_rd("stall", 1'b0, 32'h0);
        end
        idle();                                   // c8: released, handoff
        chk_out("rel", 1'b1, 32'h0, 32'h00100513);
        idle();                                   // new c0 at 4
        chk_rd("next0", 1'b1, 32'h4);
        chk("next0_valid", {31'b0, inst_valid}, 32'h0);
        chk("next0_pc_hold", pc_o, 32'h0);
        repeat (4) idle();
        idle();                                   // c5 of second instruction
        chk_out("i1", 1'b1, 32'h4, 32'h00200093);
        idle();
        chk_rd("i2_c0", 1'b1, 32'h8);

        // mem_busy during c1..c2
        do_reset();
        idle(); chk_rd("b_c0", 1'b1, 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1); chk_rd("b_c1", 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1); chk_rd("b_c2", 1'b0, 32'h0);
        idle(); chk_rd("b_c3", 1'b1, 32'h1);
        idle(); idle(); idle();                   // c4..c6
        chk("b_c6_valid", {31'b0, inst_valid}, 32'h0);
        idle();                                   // c7
        chk_out("b_c7", 1'b1, 32'h0, 32'h00100513);

        // Jump mid-fetch to an unaligned target
        do_reset();
        idle(); idle();                           // c0, c1
        cyc(1'b0, 1'b0, 1'b1, 32'h102, 1'b0);     // c2
        chk_rd("j_c2", 1'b0, 32'h0);
        idle(); chk_rd("j_c3", 1'b1, 32'h100);
        repeat (3) idle();
        idle();                                   // c7
        chk("j_c7_valid", {31'b0, inst_valid}, 32'h0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);       // c8, stall so it stays put
        chk_out("j_c8", 1'b1, 32'h100, 32'hdeadbeef);

        // Jump while VALID and stalled
        cyc(1'b0, 1'b1, 1'b1, 32'h4, 1'b0);
        chk_rd("jv_rd", 1'b0, 32'h0);
        idle();
        chk_out("jv_next", 1'b0, 32'h100, 32'hdeadbeef);
        chk_rd("jv_next", 1'b1, 32'h4);
        repeat (4) idle();
        idle();
        chk_out("jv_done", 1'b1, 32'h4, 32'h00200093);

        // Reset (with jump) mid-fetch clears registered outputs
        idle(); idle(); idle();                   // next fetch c0..c2 at 8
        cyc(1'b1, 1'b0, 1'b1, 32'h100, 1'b0);     // c3
        idle();
        chk_out("r_after", 1'b0, 32'h0, 32'h0);
        chk_rd("r_after", 1'b1, 32'h0);
        repeat (4) idle();
        idle();
        chk_out("r_refetch", 1'b1, 32'h0, 32'h00100513);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
